// File: rtl/instruction_fetch.sv
// Fetch stage: PC register drives a zero-latency program memory; the returned word is
// registered and offered to the decoder with its PC, with stall, redirect/flush and halt.
module instruction_fetch #(
  parameter int unsigned           ADDR_WIDTH = 8,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0,
  parameter logic [31:0]           HALT_WORD  = 32'hFFFF_FFFF
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  enable_i,
  output logic [ADDR_WIDTH-1:0] imem_addr_o,
  input  logic [31:0]           imem_instr_i,
  input  logic                  redirect_i,
  input  logic [ADDR_WIDTH-1:0] redirect_pc_i,
  output logic [31:0]           instr_o,
  output logic [ADDR_WIDTH-1:0] pc_o,
  output logic                  valid_o,
  input  logic                  ready_i,
  output logic                  halted_o,
  output logic [15:0]           fetch_count_o,
  output logic [1:0]            state_o
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_RUN    = 2'd1,
    S_HALTED = 2'd2
  } state_t;

  state_t                r_state;
  state_t                w_state_d;
  logic [ADDR_WIDTH-1:0] r_pc;
  logic [ADDR_WIDTH-1:0] w_pc_d;
  logic [31:0]           r_instr;
  logic [ADDR_WIDTH-1:0] r_pc_out;
  logic                  r_valid;
  logic                  w_valid_d;
  logic [15:0]           r_count;
  logic                  w_load;
  logic                  w_accept;
  logic                  w_is_halt;

  // Handshake: a transfer happens on a rising edge where valid_o && ready_i; while
  // valid_o && !ready_i the offered instr_o/pc_o and the PC are frozen.
  assign w_accept  = r_valid && ready_i;
  assign w_is_halt = (imem_instr_i == HALT_WORD);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) r_state <= S_IDLE;
    else         r_state <= w_state_d;
  end

  always_comb begin
    w_state_d = r_state;
    w_pc_d    = r_pc;
    w_valid_d = r_valid;
    w_load    = 1'b0;
    // Redirect wins over everything and suppresses the load in its own cycle.
    if (redirect_i) begin
      w_state_d = S_RUN;
      w_pc_d    = {redirect_pc_i[ADDR_WIDTH-1:2], 2'b00};
      w_valid_d = 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (enable_i) w_state_d = S_RUN;
        end
        S_RUN: begin
          if (enable_i && (!r_valid || ready_i)) begin
            w_load    = 1'b1;
            w_valid_d = 1'b1;
            if (w_is_halt) w_state_d = S_HALTED;
            else           w_pc_d    = r_pc + ADDR_WIDTH'(4);
          end else if (w_accept) begin
            w_valid_d = 1'b0;
          end
        end
        S_HALTED: begin
          if (w_accept) w_valid_d = 1'b0;
        end
        default: w_state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_pc     <= RESET_PC;
      r_instr  <= '0;
      r_pc_out <= '0;
      r_valid  <= 1'b0;
      r_count  <= '0;
    end else begin
      r_pc    <= w_pc_d;
      r_valid <= w_valid_d;
      if (w_load) begin
        r_instr  <= imem_instr_i;
        r_pc_out <= r_pc;
      end
      // An accept in a redirect cycle still counts; the count saturates.
      if (w_accept && (r_count != 16'hFFFF)) r_count <= r_count + 16'd1;
    end
  end

  assign imem_addr_o   = r_pc;
  assign instr_o       = r_instr;
  assign pc_o          = r_pc_out;
  assign valid_o       = r_valid;
  assign halted_o      = (r_state == S_HALTED);
  assign fetch_count_o = r_count;
  assign state_o       = r_state;

endmodule

// File: tb/tb_instruction_fetch.sv
// Bench for instruction_fetch: directed scenarios plus random traffic, with a
// scoreboard of expected (pc, instr) accepts derived from program-walk rules.
module tb_instruction_fetch;

  localparam int          AW   = 8;
  localparam logic [31:0] HALT = 32'hFFFF_FFFF;

  logic          clk_i;
  logic          rst_ni;
  logic          enable_i;
  logic [AW-1:0] imem_addr_o;
  logic [31:0]   imem_instr_i;
  logic          redirect_i;
  logic [AW-1:0] redirect_pc_i;
  logic [31:0]   instr_o;
  logic [AW-1:0] pc_o;
  logic          valid_o;
  logic          ready_i;
  logic          halted_o;
  logic [15:0]   fetch_count_o;
  logic [1:0]    state_o;

  logic [31:0] mem [64];
  assign imem_instr_i = mem[imem_addr_o[7:2]];

  instruction_fetch #(.ADDR_WIDTH(AW), .RESET_PC(8'h00), .HALT_WORD(HALT)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .enable_i(enable_i), .imem_addr_o(imem_addr_o),
    .imem_instr_i(imem_instr_i), .redirect_i(redirect_i), .redirect_pc_i(redirect_pc_i),
    .instr_o(instr_o), .pc_o(pc_o), .valid_o(valid_o), .ready_i(ready_i),
    .halted_o(halted_o), .fetch_count_o(fetch_count_o), .state_o(state_o)
  );

  // clock / reset
  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  int checks = 0;
  int errors = 0;

  // expected accept entries: {segment[15:0], pc[7:0], instr[31:0]}
  logic [55:0] exp_q[$];
  logic [15:0] seg     = 16'd0;
  logic [15:0] cur_seg = 16'd0;
  int          model_count = 0;
  int          total_accepts = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] rand_word();
    logic [31:0] w;
    w = $urandom();
    if (w == HALT) w = 32'h0;
    return w;
  endfunction

  // Reference: from a start address the decoder must see consecutive words up to
  // and including the first halt word, then nothing until the next redirect/reset.
  task automatic push_walk(input logic [7:0] start);
    logic [7:0] a;
    a = start;
    for (int k = 0; k < 200; k++) begin
      exp_q.push_back({seg, a, mem[a[7:2]]});
      if (mem[a[7:2]] == HALT) break;
      a = a + 8'd4;
    end
  endtask

  // driver tasks
  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic do_redirect(input logic [7:0] target);
    redirect_i    = 1'b1;
    redirect_pc_i = target;
    seg           = seg + 16'd1;
    push_walk({target[7:2], 2'b00});
  endtask

  task automatic reset_assert();
    rst_ni = 1'b0;
    #1;
    check("rst_valid", {31'd0, valid_o}, 32'd0);
    check("rst_count", {16'd0, fetch_count_o}, 32'd0);
    check("rst_pc_o", {24'd0, pc_o}, 32'd0);
    check("rst_instr", instr_o, 32'd0);
    check("rst_halted", {31'd0, halted_o}, 32'd0);
    check("rst_imem_addr", {24'd0, imem_addr_o}, 32'd0);
  endtask

  task automatic reset_release();
    exp_q.delete();
    seg         = seg + 16'd1;
    cur_seg     = seg;
    model_count = 0;
    push_walk(8'h00);
    rst_ni = 1'b1;
  endtask

  // monitor / scoreboard
  logic        prev_hold = 1'b0;
  logic [7:0]  hold_pc;
  logic [31:0] hold_instr;

  always @(negedge clk_i) begin
    logic [55:0] e;
    if (!rst_ni) begin
      prev_hold = 1'b0;
    end else begin
      check("fetch_count", {16'd0, fetch_count_o}, model_count);
      if (prev_hold) begin
        check("hold_valid", {31'd0, valid_o}, 32'd1);
        check("hold_pc", {24'd0, pc_o}, {24'd0, hold_pc});
        check("hold_instr", instr_o, hold_instr);
      end
      if (valid_o && ready_i) begin
        while (exp_q.size() > 0 && exp_q[0][55:40] != cur_seg) void'(exp_q.pop_front());
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL accept_unexpected actual_pc=%h required=no_accept", pc_o);
        end else begin
          e = exp_q.pop_front();
          check("accept_pc", {24'd0, pc_o}, {24'd0, e[39:32]});
          check("accept_instr", instr_o, e[31:0]);
        end
        if (model_count < 65535) model_count++;
        total_accepts++;
      end
      if (redirect_i) cur_seg = cur_seg + 16'd1;
      prev_hold  = valid_o && !ready_i && !redirect_i;
      hold_pc    = pc_o;
      hold_instr = instr_o;
    end
  end

  initial begin
    int r;
    rst_ni = 1'b0; enable_i = 1'b0; ready_i = 1'b0;
    redirect_i = 1'b0; redirect_pc_i = '0;
    for (int i = 0; i < 64; i++) mem[i] = rand_word();
    #2;

    // startup latency, sequential fetch, halt and exit via redirect
    reset_assert();
    for (int i = 0; i < 64; i++) mem[i] = rand_word();
    mem[4] = HALT;
    step();
    enable_i = 1'b1; ready_i = 1'b1;
    reset_release();
    step();
    check("idle_valid", {31'd0, valid_o}, 32'd0);
    check("idle_addr", {24'd0, imem_addr_o}, 32'h00);
    for (int k = 0; k < 4; k++) begin
      step();
      check("seq_valid", {31'd0, valid_o}, 32'd1);
      check("seq_pc", {24'd0, pc_o}, 4 * k);
      check("seq_instr", instr_o, mem[k]);
      check("seq_addr", {24'd0, imem_addr_o}, 4 * k + 4);
    end
    step();
    check("four_accepts", {16'd0, fetch_count_o}, 32'd4);
    check("halt_pc", {24'd0, pc_o}, 32'h10);
    check("halt_instr", instr_o, HALT);
    check("halt_flag", {31'd0, halted_o}, 32'd1);
    step();
    check("halt_drained", {31'd0, valid_o}, 32'd0);
    check("halt_addr", {24'd0, imem_addr_o}, 32'h10);
    check("halt_flag2", {31'd0, halted_o}, 32'd1);
    do_redirect(8'h23);
    step();
    redirect_i = 1'b0;
    check("unhalt_flag", {31'd0, halted_o}, 32'd0);
    check("unhalt_addr", {24'd0, imem_addr_o}, 32'h20);
    step();
    check("unhalt_pc", {24'd0, pc_o}, 32'h20);
    check("unhalt_valid", {31'd0, valid_o}, 32'd1);

    // backpressure, redirect under stall, wrap, then mid-stream reset
    step();
    reset_assert();
    for (int i = 0; i < 64; i++) mem[i] = rand_word();
    step();
    reset_release();
    step(); step(); step();
    check("bp_pc_start", {24'd0, pc_o}, 32'h04);
    ready_i = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step();
      check("bp_pc", {24'd0, pc_o}, 32'h04);
      check("bp_instr", instr_o, mem[1]);
      check("bp_addr", {24'd0, imem_addr_o}, 32'h08);
    end
    ready_i = 1'b1;
    step();
    check("bp_next_pc", {24'd0, pc_o}, 32'h08);
    ready_i = 1'b0;
    step();
    check("rd_pre_count", {16'd0, fetch_count_o}, 32'd2);
    do_redirect(8'h40);
    step();
    redirect_i = 1'b0;
    check("rd_flush_valid", {31'd0, valid_o}, 32'd0);
    check("rd_flush_count", {16'd0, fetch_count_o}, 32'd2);
    ready_i = 1'b1;
    step();
    check("rd_target_pc", {24'd0, pc_o}, 32'h40);
    do_redirect(8'hFC);
    step();
    redirect_i = 1'b0;
    check("wrap_addr", {24'd0, imem_addr_o}, 32'hFC);
    check("wrap_count", {16'd0, fetch_count_o}, 32'd3);
    step();
    check("wrap_pc_fc", {24'd0, pc_o}, 32'hFC);
    step();
    check("wrap_pc_00", {24'd0, pc_o}, 32'h00);
    check("wrap_instr", instr_o, mem[0]);
    check("mid_valid_before", {31'd0, valid_o}, 32'd1);
    reset_assert();

    // random traffic
    for (int i = 0; i < 64; i++) mem[i] = ($urandom_range(0, 15) == 0) ? HALT : rand_word();
    step();
    reset_release();
    for (int c = 0; c < 4000; c++) begin
      step();
      redirect_i = 1'b0;
      ready_i    = ($urandom_range(0, 9) < 7);
      enable_i   = ($urandom_range(0, 19) < 17);
      r = $urandom_range(0, 999);
      if (r < 30) begin
        do_redirect(8'($urandom_range(0, 255)));
      end else if (r < 33) begin
        reset_assert();
        for (int i = 0; i < 64; i++) mem[i] = ($urandom_range(0, 15) == 0) ? HALT : rand_word();
        step();
        reset_release();
      end
    end
    step();
    redirect_i = 1'b0;
    check("random_activity", {31'd0, (total_accepts > 200)}, 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/instruction_fetch.md
Name: instruction_fetch

Overview:
Program counter and fetch stage that drives the byte address of the combinational program memory and captures its 32-bit little-endian instruction word into an output register. Presents each instruction with its PC to the decoder over a valid/ready handshake. Supports stall via backpressure, control-flow redirect with flush, a halt word and an accepted-instruction counter.

Parameters:
ADDR_WIDTH, 8, width of PC and memory byte address; PC wraps modulo 2^ADDR_WIDTH.
RESET_PC, 0, PC value loaded on reset; low 2 bits must be 0.
HALT_WORD, 32'hFFFF_FFFF, instruction encoding that stops fetching.

Ports:
clk_i  in  1  clock; all state updates on rising edge.
rst_ni  in  1  reset, asynchronous, active-low.
enable_i  in  1  permits leaving IDLE and issuing new fetches.
imem_addr_o  out  ADDR_WIDTH  byte address to program memory; equals PC register.
imem_instr_i  in  32  instruction word returned combinationally for imem_addr_o.
redirect_i  in  1  load new PC and flush the output register.
redirect_pc_i  in  ADDR_WIDTH  redirect target; bits [1:0] ignored (forced 0).
instr_o  out  32  registered instruction.
pc_o  out  ADDR_WIDTH  address instr_o was fetched from.
valid_o  out  1  instr_o/pc_o hold a valid instruction.
ready_i  in  1  decoder accepts instr_o this cycle when valid_o.
halted_o  out  1  high in HALTED state.
fetch_count_o  out  16  count of accepted instructions (valid_o && ready_i), saturating.

Behaviour:
- Reset (async, rst_ni=0): PC=RESET_PC, state=IDLE, instr_o=0, pc_o=0, valid_o=0, halted_o=0, fetch_count_o=0. Mid-operation reset discards everything immediately.
- imem_addr_o = PC (combinational from register); memory read is zero-latency, so word captured same cycle.
- States: IDLE, RUN, HALTED.
- IDLE: no fetch; -> RUN on next edge when enable_i=1.
- RUN: load = enable_i && (!valid_o || ready_i). On load: instr_o<=imem_instr_i, pc_o<=PC, valid_o<=1. If word != HALT_WORD: PC<=PC+4 (wraps, 0xFC->0x00 at default width). If word == HALT_WORD: PC unchanged, state->HALTED. When valid_o && ready_i && !load (enable_i=0): valid_o<=0.
- Backpressure: valid_o && !ready_i holds instr_o, pc_o, PC stable; no memory word lost or skipped.
- Sustained throughput: one instruction per cycle while ready_i=1 and enable_i=1.
- HALTED: halted_o=1; no loads; held HALT_WORD stays valid until accepted, then valid_o<=0. Exit only via redirect.
- Redirect (highest priority, any state incl. IDLE/HALTED): next edge PC<={redirect_pc_i[ADDR_WIDTH-1:2],2'b00}, valid_o<=0, state<=RUN, no load that cycle. An instruction accepted (valid_o && ready_i) in the redirect cycle counts as accepted; otherwise it is dropped. First post-redirect instruction valid earliest one cycle after flush cycle.
- enable_i=0 in RUN: no new loads; held output still drains via ready_i.
- fetch_count_o increments by 1 on every valid_o && ready_i edge; saturates at 16'hFFFF.
- pc_o/instr_o are don't-care when valid_o=0 but must not change while valid_o && !ready_i.

Test Plan:
- Reset, enable_i=1, ready_i=1, memory words W0..W3 at 0x00..0x0C -> imem_addr_o 0x00,0x04,0x08,0x0C on successive cycles; valid_o first high 2 cycles after rst_ni release (IDLE then load); pc_o 0x00,0x04,... each with matching instr_o; fetch_count_o=4 after four accepts.
- ready_i=0 for 3 cycles while valid_o=1 at pc_o=0x04 -> instr_o, pc_o, imem_addr_o=0x08 frozen; on ready_i=1 next presented pc_o=0x08, no skip/duplicate.
- PC at 0xFC, ready_i=1 -> pc_o=0xFC then pc_o=0x00 (wrap).
- Word at 0x10 = 32'hFFFF_FFFF -> presented with pc_o=0x10, halted_o=1, imem_addr_o stays 0x10, after accept valid_o=0; then redirect_i=1, redirect_pc_i=0x23 -> halted_o=0, next fetch pc_o=0x20.
- Redirect while valid_o=1, ready_i=0 at pc_o=0x08 to 0x40 -> next cycle valid_o=0, fetch_count_o unchanged; following cycle pc_o=0x40.
- Assert rst_ni=0 mid-stream with valid_o=1 -> valid_o, fetch_count_o, pc_o cleared asynchronously before next edge; PC=RESET_PC.
